fifo_axis_tx: RTL and testbench

//  Reader end of the stream FIFO: pops words from a first-word-fall-through FIFO

---
 rtl/fifo_axis_tx_if.sv | 33 +++
 rtl/fifo_axis_tx.sv | 147 ++++++++++++++
 tb/tb_fifo_axis_tx.sv | 285 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fifo_axis_tx_if.sv
// FIFO read port and AXI4-Stream master bundle for the stream FIFO reader.
// master: the reader/transmitter side; slave: the FIFO plus downstream consumer side.
interface fifo_axis_tx_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  fifo_rd_en;
    logic [DATA_WIDTH-1:0] fifo_dout;
    logic                  fifo_empty;
    logic [DATA_WIDTH-1:0] m_axis_tdata;
    logic                  m_axis_tvalid;
    logic                  m_axis_tready;
    logic                  m_axis_tlast;

    modport master (
        output fifo_rd_en,
        input  fifo_dout,
        input  fifo_empty,
        output m_axis_tdata,
        output m_axis_tvalid,
        output m_axis_tlast,
        input  m_axis_tready
    );

    modport slave (
        input  fifo_rd_en,
        output fifo_dout,
        output fifo_empty,
        input  m_axis_tdata,
        input  m_axis_tvalid,
        input  m_axis_tlast,
        output m_axis_tready
    );
endinterface

// File: rtl/fifo_axis_tx.sv
// Pops words from a FWFT FIFO and sends them as one AXI4-Stream packet of pkt_len beats.
// Optional stall counter enabled by defining FIFO_AXIS_TX_STALL_CNT_EN.
//
// state | meaning
// IDLE  | waiting for start; FIFO not read
// SEND  | popping words into the output register until pkt_len words taken
// DRAIN | all words popped; waiting for the tlast beat to be accepted
module fifo_axis_tx #(
    parameter int DATA_WIDTH      = 32,
    parameter int LEN_WIDTH       = 16,
    parameter int STALL_CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [LEN_WIDTH-1:0] pkt_len,
    output logic                 busy,
    output logic                 done,
    fifo_axis_tx_if.master       bus
`ifdef FIFO_AXIS_TX_STALL_CNT_EN
    ,
    output logic [STALL_CNT_WIDTH-1:0] stall_cnt
`endif
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SEND  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    if (LEN_WIDTH < 1 || STALL_CNT_WIDTH < 1) begin : g_param_chk
        $error("fifo_axis_tx: LEN_WIDTH and STALL_CNT_WIDTH must be at least 1");
    end

    state_t                state_q, state_d;
    logic [LEN_WIDTH-1:0]  remaining_q, remaining_d;
    logic [DATA_WIDTH-1:0] tdata_q, tdata_d;
    logic                  tvalid_q, tvalid_d;
    logic                  tlast_q, tlast_d;
    logic                  done_q, done_d;

    logic slot_free;
    logic rd_en;
    logic handshake;

    assign slot_free = !tvalid_q || bus.m_axis_tready;
    assign handshake = tvalid_q && bus.m_axis_tready;
    assign rd_en     = (state_q == SEND) && !bus.fifo_empty && slot_free
                       && (remaining_q != '0);

    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        tdata_d     = tdata_q;
        tvalid_d    = tvalid_q;
        tlast_d     = tlast_q;
        done_d      = 1'b0;

        // A pop refills the output slot in the same edge the previous beat leaves it.
        if (rd_en) begin
            tdata_d     = bus.fifo_dout;
            tvalid_d    = 1'b1;
            tlast_d     = (remaining_q == LEN_WIDTH'(1));
            remaining_d = remaining_q - LEN_WIDTH'(1);
        end else if (handshake) begin
            tvalid_d = 1'b0;
            tlast_d  = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (start) begin
                    if (pkt_len != '0) begin
                        state_d     = SEND;
                        remaining_d = pkt_len;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            SEND: begin
                if (rd_en && remaining_q == LEN_WIDTH'(1)) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (handshake && tlast_q) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            remaining_q <= '0;
            tdata_q     <= '0;
            tvalid_q    <= 1'b0;
            tlast_q     <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            tdata_q     <= tdata_d;
            tvalid_q    <= tvalid_d;
            tlast_q     <= tlast_d;
            done_q      <= done_d;
        end
    end

`ifdef FIFO_AXIS_TX_STALL_CNT_EN
    logic [STALL_CNT_WIDTH-1:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (state_q == IDLE && start) begin
            stall_cnt_d = '0;
        end else if (tvalid_q && !bus.m_axis_tready && stall_cnt_q != '1) begin
            stall_cnt_d = stall_cnt_q + STALL_CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
`endif

    assign busy              = (state_q != IDLE);
    assign done              = done_q;
    assign bus.fifo_rd_en    = rd_en;
    assign bus.m_axis_tdata  = tdata_q;
    assign bus.m_axis_tvalid = tvalid_q;
    assign bus.m_axis_tlast  = tlast_q;

endmodule

// File: tb/tb_fifo_axis_tx.sv
// Bench for fifo_axis_tx: FWFT FIFO model feeding the DUT, scoreboard of expected beats.
// Builds with or without FIFO_AXIS_TX_STALL_CNT_EN.
module tb_fifo_axis_tx;
    localparam int DW = 32;
    localparam int LW = 16;
    localparam int SW = 16;

    typedef logic [DW:0] beat_t;   // {tlast, tdata}

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic [LW-1:0] pkt_len = '0;
    logic          busy;
    logic          done;
`ifdef FIFO_AXIS_TX_STALL_CNT_EN
    logic [SW-1:0] stall_cnt;
`endif

    fifo_axis_tx_if #(.DATA_WIDTH(DW)) bus_if ();

    fifo_axis_tx #(
        .DATA_WIDTH     (DW),
        .LEN_WIDTH      (LW),
        .STALL_CNT_WIDTH(SW)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .pkt_len  (pkt_len),
        .busy     (busy),
        .done     (done),
        .bus      (bus_if)
`ifdef FIFO_AXIS_TX_STALL_CNT_EN
        ,
        .stall_cnt(stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // FWFT FIFO model: empty flag is registered and lags a write by one cycle.
    logic [DW-1:0] mem[$];
    logic [DW-1:0] wr_q[$];
    int underflow = 0;

    always @(posedge clk) begin
        if (bus_if.fifo_rd_en) begin
            if (mem.size() == 0) underflow++;
            else void'(mem.pop_front());
        end
        bus_if.fifo_empty <= (mem.size() == 0);
        if (wr_q.size() > 0) mem.push_back(wr_q.pop_front());
        bus_if.fifo_dout <= (mem.size() > 0) ? mem[0] : '0;
    end

    beat_t sb[$];
    int    hs_cnt = 0, done_cnt = 0, done_cyc = 0, last_hs_cyc = 0;
    int    first_tv_cyc = -1, rd_cnt = 0, busy_cnt = 0, tv_cnt = 0;
    logic  prev_stall = 1'b0;
    beat_t prev_beat = '0;

    always @(negedge clk) begin
        beat_t e;
        if (!reset) begin
            if (bus_if.fifo_rd_en) rd_cnt++;
            if (busy) busy_cnt++;
            if (bus_if.m_axis_tvalid) tv_cnt++;
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (bus_if.m_axis_tvalid && first_tv_cyc < 0) first_tv_cyc = cyc;
            if (prev_stall) begin
                chk("hold_valid", 64'(bus_if.m_axis_tvalid), 64'(1));
                chk("hold_beat", 64'({bus_if.m_axis_tlast, bus_if.m_axis_tdata}), 64'(prev_beat));
            end
            if (bus_if.m_axis_tvalid && bus_if.m_axis_tready) begin
                hs_cnt++;
                last_hs_cyc = cyc;
                if (sb.size() == 0) begin
                    chk("extra_beat", 64'(bus_if.m_axis_tdata), 64'hDEAD);
                end else begin
                    e = sb.pop_front();
                    chk("beat_data", 64'(bus_if.m_axis_tdata), 64'(e[DW-1:0]));
                    chk("beat_last", 64'(bus_if.m_axis_tlast), 64'(e[DW]));
                end
            end
            prev_stall = bus_if.m_axis_tvalid && !bus_if.m_axis_tready;
            prev_beat  = {bus_if.m_axis_tlast, bus_if.m_axis_tdata};
        end else begin
            prev_stall = 1'b0;
        end
    end

    int seq = 0;
    int exp_ptr = 0;

    function automatic logic [DW-1:0] word(input int n);
        return 32'hC0DE_0000 + DW'(n);
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push_words(input int n);
        for (int i = 0; i < n; i++) begin
            wr_q.push_back(word(seq));
            seq++;
        end
    endtask

    task automatic expect_beats(input int n, input bit last_on_end);
        for (int i = 0; i < n; i++) begin
            sb.push_back({(last_on_end && i == n - 1), word(exp_ptr)});
            exp_ptr++;
        end
    endtask

    // mode 0: tready=1; 1: tready toggles 1,0,...; 2: refill 3 words at k=10;
    // 3: second start (pkt_len=5) raised while sending.
    task automatic send(input int len, input int mode, output int s_cyc);
        int d0;
        int k;
        d0 = done_cnt;
        s_cyc = cyc;
        start = 1'b1;
        pkt_len = LW'(len);
        bus_if.m_axis_tready = 1'b1;
        tick(1);
        start = 1'b0;
        k = 1;
        while (k < 80 && done_cnt == d0) begin
            bus_if.m_axis_tready = (mode == 1) ? (k % 2 == 0) : 1'b1;
            if (mode == 2 && k == 8) chk("gap_tvalid", 64'(bus_if.m_axis_tvalid), 64'(0));
            if (mode == 2 && k == 10) push_words(3);
            if (mode == 3 && k == 2) begin
                start = 1'b1;
                pkt_len = LW'(5);
            end
            if (mode == 3 && k == 3) start = 1'b0;
            tick(1);
            k++;
        end
        bus_if.m_axis_tready = 1'b1;
        chk("done_seen", 64'(done_cnt != d0), 64'(1));
    endtask

    int s, h0, r0, d0, b0, t0;

    initial begin
        bus_if.m_axis_tready = 1'b1;

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_done", 64'(done), 64'(0));
        chk("rst_tvalid", 64'(bus_if.m_axis_tvalid), 64'(0));
        chk("rst_tlast", 64'(bus_if.m_axis_tlast), 64'(0));
        chk("rst_tdata", 64'(bus_if.m_axis_tdata), 64'(0));
        chk("rst_rd_en", 64'(bus_if.fifo_rd_en), 64'(0));
`ifdef FIFO_AXIS_TX_STALL_CNT_EN
        chk("rst_stall", 64'(stall_cnt), 64'(0));
`endif
        @(posedge clk);
        #1 reset = 1'b0;
        tick(2);

        // 4 words, unthrottled: back-to-back beats, tlast on the 4th
        push_words(4);
        tick(6);
        expect_beats(4, 1'b1);
        h0 = hs_cnt; r0 = rd_cnt; d0 = done_cnt; first_tv_cyc = -1;
        send(4, 0, s);
        chk("t1_latency", 64'(first_tv_cyc), 64'(s + 2));
        chk("t1_beats", 64'(hs_cnt - h0), 64'(4));
        chk("t1_pops", 64'(rd_cnt - r0), 64'(4));
        chk("t1_b2b", 64'(last_hs_cyc - first_tv_cyc), 64'(3));
        chk("t1_done_cyc", 64'(done_cyc), 64'(last_hs_cyc + 1));
        tick(3);
        chk("t1_done_once", 64'(done_cnt - d0), 64'(1));
        chk("t1_busy_end", 64'(busy), 64'(0));
`ifdef FIFO_AXIS_TX_STALL_CNT_EN
        chk("t1_stall", 64'(stall_cnt), 64'(0));
`endif

        // 3 words with tready toggling: beats held during stalls
        push_words(3);
        tick(5);
        expect_beats(3, 1'b1);
        h0 = hs_cnt; r0 = rd_cnt;
        send(3, 1, s);
        chk("t2_beats", 64'(hs_cnt - h0), 64'(3));
        chk("t2_pops", 64'(rd_cnt - r0), 64'(3));
        chk("t2_done_cyc", 64'(done_cyc), 64'(last_hs_cyc + 1));
`ifdef FIFO_AXIS_TX_STALL_CNT_EN
        chk("t2_stall", 64'(stall_cnt), 64'(2));
`endif
        tick(2);

        // FIFO runs dry after 2 of 5 words, refilled later
        push_words(2);
        tick(4);
        expect_beats(5, 1'b1);
        h0 = hs_cnt; r0 = rd_cnt;
        send(5, 2, s);
        chk("t3_beats", 64'(hs_cnt - h0), 64'(5));
        chk("t3_pops", 64'(rd_cnt - r0), 64'(5));
        tick(2);

        // zero-length packet: done only, FIFO untouched
        push_words(1);
        tick(4);
        h0 = hs_cnt; r0 = rd_cnt; d0 = done_cnt; b0 = busy_cnt; t0 = tv_cnt;
        send(0, 0, s);
        chk("t4_done_cyc", 64'(done_cyc), 64'(s + 1));
        tick(3);
        chk("t4_done_once", 64'(done_cnt - d0), 64'(1));
        chk("t4_pops", 64'(rd_cnt - r0), 64'(0));
        chk("t4_tvalid", 64'(tv_cnt - t0), 64'(0));
        chk("t4_busy", 64'(busy_cnt - b0), 64'(0));

        // start during SEND must not restart or resize the packet
        push_words(5);
        tick(7);
        expect_beats(3, 1'b1);
        h0 = hs_cnt; r0 = rd_cnt; d0 = done_cnt;
        send(3, 3, s);
        tick(4);
        chk("t5_beats", 64'(hs_cnt - h0), 64'(3));
        chk("t5_pops", 64'(rd_cnt - r0), 64'(3));
        chk("t5_done_once", 64'(done_cnt - d0), 64'(1));
        chk("t5_idle", 64'(busy), 64'(0));

        // reset during beat 2 of 8, then a 2-beat packet from the following words
        push_words(5);
        tick(7);
        expect_beats(1, 1'b0);
        h0 = hs_cnt;
        start = 1'b1;
        pkt_len = LW'(8);
        tick(1);
        start = 1'b0;
        tick(2);
        reset = 1'b1;
        #1;
        chk("t6_rst_tvalid", 64'(bus_if.m_axis_tvalid), 64'(0));
        chk("t6_rst_busy", 64'(busy), 64'(0));
        chk("t6_rst_rd_en", 64'(bus_if.fifo_rd_en), 64'(0));
        chk("t6_rst_tdata", 64'(bus_if.m_axis_tdata), 64'(0));
        exp_ptr++;   // second word was popped and then lost with the in-flight beat
        tick(2);
        reset = 1'b0;
        tick(2);
        chk("t6_beats_pre", 64'(hs_cnt - h0), 64'(1));
        expect_beats(2, 1'b1);
        h0 = hs_cnt;
        send(2, 0, s);
        chk("t6_beats_post", 64'(hs_cnt - h0), 64'(2));
        tick(3);

        chk("sb_empty", 64'(sb.size()), 64'(0));
        chk("no_underflow", 64'(underflow), 64'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
